// File: rtl/p405s_dcu_linewrbuf_if.sv
// Fill/store/array-write signal bundle for the DCU line write buffer.
// The master drives fills, stores and acks; the slave returns the array write image.
interface p405s_dcu_linewrbuf_if;
    logic          lineStart;
    logic [28:29]  startWord;
    logic          fillValid;
    logic [0:31]   fillData;
    logic          storeValid;
    logic [28:29]  storeWord;
    logic [0:3]    storeBE;
    logic [0:31]   storeData;
    logic          storeRdy;
    logic          ramWrAck;
    logic          wrReq;
    logic [0:127]  dataIn_A;
    logic [0:15]   p_dataInA;
    logic          busy;

    modport master (
        output lineStart, startWord, fillValid, fillData,
               storeValid, storeWord, storeBE, storeData, ramWrAck,
        input  storeRdy, wrReq, dataIn_A, p_dataInA, busy
    );

    modport slave (
        input  lineStart, startWord, fillValid, fillData,
               storeValid, storeWord, storeBE, storeData, ramWrAck,
        output storeRdy, wrReq, dataIn_A, p_dataInA, busy
    );
endinterface

// File: rtl/p405s_dcu_linewrbuf.sv
// DCU line write buffer: gathers a wrapped 4-word fill, merges stores,
// and holds one inverted-polarity line write with per-byte parity until acked.
//
// state   | meaning
// S_IDLE  | no line open; waits for lineStart
// S_FILL  | accepting fill words (critical word first, wrapping) and store merges
// S_WRITE | line complete and frozen; wrReq held until ramWrAck
module p405s_dcu_linewrbuf (
    input  logic                   CB,
    input  logic                   reset,
    p405s_dcu_linewrbuf_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [0:127]  line_buf_q, line_buf_d;
    logic [0:15]   st_mask_q, st_mask_d;
    logic [1:0]    fill_cnt_q, fill_cnt_d;
    logic [1:0]    start_w_q, start_w_d;
    logic          wr_req_q, wr_req_d;
    logic          busy_q, busy_d;
    logic          store_rdy_q, store_rdy_d;
    logic [1:0]    fill_word;

    always_comb begin
        state_d    = state_q;
        line_buf_d = line_buf_q;
        st_mask_d  = st_mask_q;
        fill_cnt_d = fill_cnt_q;
        start_w_d  = start_w_q;
        fill_word  = start_w_q + fill_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.lineStart) begin
                    line_buf_d = '0;
                    st_mask_d  = '0;
                    fill_cnt_d = '0;
                    start_w_d  = bus.startWord;
                    state_d    = S_FILL;
                end
            end

            S_FILL: begin
                // Store bytes win over fill bytes, both this cycle and sticky via st_mask.
                for (int w = 0; w < 4; w++) begin
                    for (int b = 0; b < 4; b++) begin
                        if (bus.storeValid && (bus.storeWord == 2'(w)) && bus.storeBE[b]) begin
                            line_buf_d[32*w + 8*b +: 8] = bus.storeData[8*b +: 8];
                            st_mask_d[4*w + b]          = 1'b1;
                        end else if (bus.fillValid && (fill_word == 2'(w)) &&
                                     !st_mask_q[4*w + b]) begin
                            line_buf_d[32*w + 8*b +: 8] = bus.fillData[8*b +: 8];
                        end
                    end
                end

                if (bus.fillValid) begin
                    if (fill_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 2'd1;
                    end
                end
            end

            S_WRITE: begin
                if (bus.ramWrAck) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        wr_req_d    = (state_d == S_WRITE);
        busy_d      = (state_d != S_IDLE);
        store_rdy_d = (state_d == S_FILL);
    end

    always_ff @(posedge CB) begin
        if (reset) begin
            state_q     <= S_IDLE;
            line_buf_q  <= '0;
            st_mask_q   <= '0;
            fill_cnt_q  <= '0;
            start_w_q   <= '0;
            wr_req_q    <= 1'b0;
            busy_q      <= 1'b0;
            store_rdy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_buf_q  <= line_buf_d;
            st_mask_q   <= st_mask_d;
            fill_cnt_q  <= fill_cnt_d;
            start_w_q   <= start_w_d;
            wr_req_q    <= wr_req_d;
            busy_q      <= busy_d;
            store_rdy_q <= store_rdy_d;
        end
    end

    // The data array stores inverted data but parity is taken over true bytes.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            bus.p_dataInA[i] = ^line_buf_q[8*i +: 8];
        end
    end

    assign bus.dataIn_A = ~line_buf_q;
    assign bus.wrReq    = wr_req_q;
    assign bus.busy     = busy_q;
    assign bus.storeRdy = store_rdy_q;

endmodule
